// File: rtl/pe_phase_rand_sched.sv
// pe_phase_rand_sched
// Purpose : Serves NUM_PE processing elements one per cycle. Each served PE
//           receives a one-hot randomize enable and a pseudo-random phase
//           taken from a 16-bit Galois LFSR. An epoch starts on request or
//           repeats every PERIOD idle cycles when auto_en is set.
// Latency : start sampled at edge t -> pe_rand_ena[0] in cycle t+1,
//           done in cycle t+NUM_PE+1 when there are no stalls.
// Backpressure: stall freezes the scan. pe_sel and the LFSR hold and
//           pe_rand_ena is forced to 0 until stall drops.
// Option  : define PE_PHASE_RAND_MASK_EN to add input pe_mask. A masked PE
//           still uses its scan slot, but it gets no enable and the LFSR
//           does not advance.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begin one epoch (sampled in IDLE only)
//   auto_en      in   re-run epochs every PERIOD cycles
//   stall        in   freeze scan; PEs cannot accept
//   pe_mask      in   [NUM_PE] 1 = skip PE (PE_PHASE_RAND_MASK_EN only)
//   seed_load    in   load LFSR from seed (IDLE only)
//   seed         in   [16] LFSR seed; zero selects 16'hACE1
//   pe_rand_ena  out  [NUM_PE] one-hot per-PE randomize enable
//   pe_sel       out  [$clog2(NUM_PE)] index of PE being served
//   rand_phase   out  [PHASE_W] random phase, valid with pe_rand_ena
//   busy         out  high in SCAN, DONE and WAIT_PERIOD
//   done         out  one-cycle end-of-epoch pulse

module pe_phase_rand_sched #(
  parameter int NUM_PE  = 8,   // 2..64
  parameter int PHASE_W = 8,   // 1..16
  parameter int PERIOD  = 64   // >= 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      auto_en,
  input  logic                      stall,
`ifdef PE_PHASE_RAND_MASK_EN
  input  logic [NUM_PE-1:0]         pe_mask,
`endif
  input  logic                      seed_load,
  input  logic [15:0]               seed,
  output logic [NUM_PE-1:0]         pe_rand_ena,
  output logic [$clog2(NUM_PE)-1:0] pe_sel,
  output logic [PHASE_W-1:0]        rand_phase,
  output logic                      busy,
  output logic                      done
);

  localparam int SEL_W = $clog2(NUM_PE);
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [15:0]      LFSR_INIT = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [SEL_W-1:0] LAST_PE   = SEL_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE,
    S_WAIT
  } state_t;

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  state_t           r_state;
  logic [SEL_W-1:0] r_pe_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_lfsr;

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic              w_scan;
  logic              w_skip;
  logic              w_serve;
  logic [NUM_PE-1:0] w_onehot;
  logic [15:0]       w_lfsr_next;
  logic [15:0]       w_seed_val;

  assign w_scan = (r_state == S_SCAN);

`ifdef PE_PHASE_RAND_MASK_EN
  // r_pe_sel is always below NUM_PE, so this index stays in range.
  assign w_skip = pe_mask[r_pe_sel];
`else
  assign w_skip = 1'b0;
`endif

  // A PE is served only in a scan cycle that is not stalled and not masked.
  // Apart from the optional mask, stall is the only input that reaches the
  // enable. Everything else comes from registered state, so the output is
  // glitch-free.
  assign w_serve  = w_scan && !stall && !w_skip;
  assign w_onehot = {{(NUM_PE-1){1'b0}}, 1'b1} << r_pe_sel;

  // Galois right-shift form: the output bit folds back through the taps.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

  // All-zero is the lock-up state of the LFSR, so a zero seed is replaced
  // by the reset value.
  assign w_seed_val = (seed == 16'h0000) ? LFSR_INIT : seed;

  // ------------------------------------------------------------------
  // FSM, PE index, period counter and LFSR
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pe_sel <= '0;
      r_cnt    <= '0;
      r_lfsr   <= LFSR_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A seed loaded in the same cycle as start is already in place
          // for the first served PE of the new epoch.
          if (seed_load) begin
            r_lfsr <= w_seed_val;
          end
          if (start) begin
            r_state  <= S_SCAN;
            r_pe_sel <= '0;
          end
        end

        S_SCAN: begin
          // The LFSR advances only when an enable is actually issued.
          if (w_serve) begin
            r_lfsr <= w_lfsr_next;
          end
          // A masked PE still uses its slot. Only stall holds the index.
          if (!stall) begin
            if (r_pe_sel == LAST_PE) begin
              r_pe_sel <= '0;
              r_state  <= S_DONE;
            end else begin
              r_pe_sel <= r_pe_sel + 1'b1;
            end
          end
        end

        S_DONE: begin
          if (auto_en) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_WAIT: begin
          // Dropping auto_en abandons the wait without starting an epoch.
          // Otherwise the counter spans exactly PERIOD cycles, and the scan
          // begins on the edge that ends the cycle in which it reads zero.
          if (!auto_en) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state  <= S_SCAN;
            r_pe_sel <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Reset forces IDLE asynchronously, so every output below drops to 0
  // in the same cycle that reset rises.
  assign pe_rand_ena = w_serve ? w_onehot : '0;
  assign pe_sel      = r_pe_sel;
  assign rand_phase  = w_serve ? r_lfsr[PHASE_W-1:0] : '0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_pe_phase_rand_sched.sv
module tb_pe_phase_rand_sched;

  localparam int NUM_PE  = 8;
  localparam int PHASE_W = 8;
  localparam int PERIOD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        stall = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [7:0]  pe_mask = 8'h00;
  logic [7:0]  pe_rand_ena;
  logic [2:0]  pe_sel;
  logic [7:0]  rand_phase;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pe_phase_rand_sched #(
    .NUM_PE (NUM_PE),
    .PHASE_W(PHASE_W),
    .PERIOD (PERIOD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .auto_en    (auto_en),
    .stall      (stall),
`ifdef PE_PHASE_RAND_MASK_EN
    .pe_mask    (pe_mask),
`endif
    .seed_load  (seed_load),
    .seed       (seed),
    .pe_rand_ena(pe_rand_ena),
    .pe_sel     (pe_sel),
    .rand_phase (rand_phase),
    .busy       (busy),
    .done       (done)
  );

  // Cycle index: the value after edge n is n. Inputs change 1ns after an
  // edge, and the monitor samples on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] ena;
    logic [2:0] sel;
    logic [7:0] ph;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // These phases are worked out by hand from 16'hACE1 with taps 0xB400:
  // ACE1 E270 7138 389C 1C4E 0E27 B313 ED89, and the state after them is C2C4.
  logic [7:0] hand_ph [8];
  initial hand_ph = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89};

  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  // Queue the expected outputs of one epoch whose start is set in cycle c.
  // PEs at index >= stall_at are shifted by stall_len cycles. Only the first
  // n_pe PEs are queued, and the done pulse is queued when with_done is set.
  task automatic push_epoch(input int c, input int stall_at, input int stall_len,
                            input logic [7:0] mask, input bit hand,
                            input int n_pe, input bit with_done);
    exp_t e;
    int   k = 0;
    for (int i = 0; i < n_pe; i++) begin
      if (!mask[i]) begin
        e.cyc = c + 1 + i + ((i >= stall_at) ? stall_len : 0);
        e.ena = 8'b1 << i;
        e.sel = 3'(i);
        e.ph  = hand ? hand_ph[k] : m_lfsr[7:0];
        e.dn  = 1'b0;
        q.push_back(e);
        m_lfsr = lstep(m_lfsr);
        k++;
      end
    end
    if (with_done) begin
      e.cyc = c + 1 + NUM_PE + stall_len;
      e.ena = 8'h00;
      e.sel = 3'd0;
      e.ph  = 8'h00;
      e.dn  = 1'b1;
      q.push_back(e);
    end
  endtask

  // Monitor: every enable or done seen on the outputs must match the next
  // expected item, including the cycle in which it appears.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && (pe_rand_ena !== 8'h00 || done !== 1'b0)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d ena=%h done=%b required=no output",
                 cyc, pe_rand_ena, done);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || pe_rand_ena !== e.ena || pe_sel !== e.sel ||
            rand_phase !== e.ph || done !== e.dn) begin
          bad++;
          $display("FAIL sb_item actual cyc=%0d ena=%h sel=%0d ph=%h done=%b required cyc=%0d ena=%h sel=%0d ph=%h done=%b",
                   cyc, pe_rand_ena, pe_sel, rand_phase, done,
                   e.cyc, e.ena, e.sel, e.ph, e.dn);
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    #12;
    check("rst_ena",   32'(pe_rand_ena), 32'h0);
    check("rst_phase", 32'(rand_phase),  32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    check("rst_done",  32'(done),        32'h0);
    check("rst_sel",   32'(pe_sel),      32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Basic epoch from the reset seed. Start and seed_load pulsed mid-scan
    // are both ignored.
    c = cyc;
    m_lfsr = 16'hACE1;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b1, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 4);
    start = 1'b1; seed_load = 1'b1; seed = 16'hFFFF;
    tick();
    start = 1'b0; seed_load = 1'b0; seed = 16'h0000;
    wait_until(c + 9);
    check("busy_in_done", 32'(busy), 32'h1);
    wait_until(c + 10);
    check("busy_after_epoch", 32'(busy), 32'h0);
    check("lfsr_model_end", 32'(m_lfsr), 32'h0000C2C4);

    // Stall for 3 cycles while pe_sel = 3.
    tick();
    c = cyc;
    push_epoch(c, 3, 3, 8'h00, 1'b0, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ena_zero", 32'(pe_rand_ena), 32'h0);
      check("stall_sel_hold", 32'(pe_sel), 32'h3);
      tick();
    end
    stall = 1'b0;
    wait_until(c + 13);
    check("busy_after_stall", 32'(busy), 32'h0);

    // Zero seed loaded together with start restarts from 16'hACE1.
    tick();
    c = cyc;
    m_lfsr = 16'hACE1;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b1, NUM_PE, 1'b1);
    seed_load = 1'b1; seed = 16'h0000; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    wait_until(c + 11);

    // Nonzero seed loaded in IDLE, then start in a later cycle.
    seed_load = 1'b1; seed = 16'h1234;
    tick();
    seed_load = 1'b0; seed = 16'h0000;
    c = cyc;
    m_lfsr = 16'h1234;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b0, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 11);

    // Auto mode: done, then PERIOD wait cycles, then the next scan. auto_en
    // is dropped during the second wait so that no third epoch starts.
    c = cyc;
    auto_en = 1'b1;
    push_epoch(c,      NUM_PE, 0, 8'h00, 1'b0, NUM_PE, 1'b1);
    push_epoch(c + 13, NUM_PE, 0, 8'h00, 1'b0, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 10);
    check("busy_in_wait", 32'(busy), 32'h1);
    wait_until(c + 13);
    check("wait_no_ena", 32'(pe_rand_ena), 32'h0);
    wait_until(c + 23);
    check("busy_in_wait2", 32'(busy), 32'h1);
    auto_en = 1'b0;
    tick();
    check("wait_abort_idle", 32'(busy), 32'h0);
    wait_until(c + 32);

    // Reset at pe_sel = 5 aborts the epoch and produces no done pulse.
    c = cyc;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b0, 5, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 6);
    check("pre_reset_sel", 32'(pe_sel), 32'h5);
    reset = 1'b1;
    #1;
    check("midrst_ena",   32'(pe_rand_ena), 32'h0);
    check("midrst_phase", 32'(rand_phase),  32'h0);
    check("midrst_busy",  32'(busy),        32'h0);
    check("midrst_done",  32'(done),        32'h0);
    check("midrst_sel",   32'(pe_sel),      32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", 32'(busy), 32'h0);
    c = cyc;
    m_lfsr = 16'hACE1;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b1, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 11);

`ifdef PE_PHASE_RAND_MASK_EN
    // PEs 1 and 3 are masked. Done keeps its timing, and the LFSR advances
    // only 6 times, which the following unmasked epoch shows.
    c = cyc;
    pe_mask = 8'h0A;
    push_epoch(c, NUM_PE, 0, 8'h0A, 1'b0, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 11);
    pe_mask = 8'h00;
    c = cyc;
    push_epoch(c, NUM_PE, 0, 8'h00, 1'b0, NUM_PE, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(c + 11);
`endif

    for (int k = 0; k < 50 && q.size() != 0; k++) tick();
    check("scoreboard_drain", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
